store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
//  Write-side partner of the load unit in the memory stage of the execution unit.
//  - Accepts one store (SB/SH/SW) at a time and checks alignment.
//  - Drives a lane-aligned write (replicated data + byte enable) to the data cache controller.
//  - Holds the request until the cache reports completion.
//  - Returns the instruction packet to the commit logic with a valid/accept handshake.
// PARAMETERS
//  XLEN           32            data/address width (byte-enable logic fixed for 32)
//  PACKET_W       64            width of the instruction packet carried alongside
//  CACHABLE_START 32'h0000_0000 first byte address of the cachable region (inclusive)
//  CACHABLE_END   32'h3FFF_FFFF last byte address of the cachable region (inclusive)
// PORTS
//  clk_i                    in   1        clock
//  rst_n_i                  in   1        reset, asynchronous, active-low
//  valid_operation_i        in   1        store request valid
//  store_address_i          in   XLEN     byte address
//  store_data_i             in   XLEN     rs2 value, data in LSBs
//  operation_i              in   2        00 SB, 01 SH, 10 SW, 11 treated as SW
//  instr_packet_i           in   PACKET_W packet of the requesting instruction
//  data_accepted_i          in   1        consumer takes the result this cycle
//  instr_packet_o           out  PACKET_W latched packet
//  done_o                   out  1        store finished (result valid)
//  misaligned_o             out  1        qualifies done_o: store was misaligned, no write issued
//  idle_o                   out  1        unit can accept a request this cycle
//  cache_ctrl_idle_i        in   1        cache controller ready for a new request
//  cache_ctrl_done_i        in   1        cache controller completed the write
//  cache_ctrl_write_o       out  1        write request
//  cache_ctrl_address_o     out  XLEN     latched address, word aligned ([1:0]=00)
//  cache_ctrl_data_o        out  XLEN     lane-replicated write data
//  cache_ctrl_byte_enable_o out  4        byte lanes to write
//  cache_ctrl_cachable_o    out  1        latched address inside [CACHABLE_START, CACHABLE_END]
// BEHAVIOUR
//  Reset
//  - FSM goes to IDLE asynchronously.
//  - Outputs at reset: done_o=0, misaligned_o=0, cache_ctrl_write_o=0, idle_o=1.
//  - Reset values: address/data/byte_enable=0, instr_packet_o=0, cachable=0.
//  - cache_ctrl_write_o and done_o decode state_CRT only, so both drop in the same cycle the reset asserts.
//  FSM states: IDLE, WAIT_CACHE, DONE. Uses 2-bit encoding.
//  IDLE
//  - idle_o=1.
//  - Accept when valid_operation_i & cache_ctrl_idle_i. On accept, latch address, data, op and packet.
//  - Lane formatting:
//    - SB: data = {4{d[7:0]}}; BE = 0001 << addr[1:0].
//    - SH: data = {2{d[15:0]}}; BE = addr[1] ? 1100 : 0011.
//    - SW: data = d; BE = 1111.
//  - Misaligned if SH with addr[0]=1, or SW with addr[1:0]!=00.
//    - Misaligned: next state DONE, misaligned flag latched 1, BE latched 0000.
//    - Aligned: next state WAIT_CACHE, misaligned flag latched 0.
//  - valid_operation_i while cache_ctrl_idle_i=0: not accepted. Requester holds the request.
//  WAIT_CACHE
//  - cache_ctrl_write_o=1.
//  - Address, data, BE and cachable stay stable until cache_ctrl_done_i=1, then next state DONE.
//  DONE
//  - done_o=1. misaligned_o = latched flag. idle_o=0.
//  - Outputs hold until data_accepted_i=1, then next state IDLE.
//  - valid_operation_i is ignored in WAIT_CACHE and DONE, including the cycle data_accepted_i is high.
//  - The next accept happens no earlier than the cycle after returning to IDLE.
//  Latency
//  - Accept at edge N; write_o high from cycle N+1.
//  - cache_ctrl_done_i in cycle M gives done_o in cycle M+1.
//  - Minimum from accept to done_o: 2 cycles (aligned), 1 cycle (misaligned).
//  Other rules
//  - Reset during WAIT_CACHE abandons the write. The cache controller must tolerate the dropped request.
//  - Cachable compare is unsigned, inclusive at both ends, done on the latched address.
// TESTING
//  1. SB addr 0x0000_1003, data 0xAABBCCDD
//     -> write_o cycle+1, addr 0x1000, data 0xDDDDDDDD, BE 1000.
//  2. SH addr 0x0000_2002, data 0x12345678
//     -> data 0x56785678, BE 1100.
//  3. SW addr 0x0000_2000, data 0xCAFEBABE; cache_done after 5 cycles; data_accepted low 3 cycles
//     -> outputs stable throughout, done_o held 4 cycles, then IDLE.
//  4. SW addr 0x0000_2001
//     -> write_o never asserts; next cycle done_o=1, misaligned_o=1.
//     SH addr 0x...1 gives the same response.
//  5. Request with cache_ctrl_idle_i=0 for 3 cycles -> no accept, idle_o stays 1.
//     Request during DONE -> ignored.
//  6. rst_n_i low mid WAIT_CACHE -> write_o=0 immediately, idle_o=1; next SB proceeds normally.
//     Also check addr 0x4000_0000 -> cachable=0 and 0x3FFF_FFFC -> cachable=1.

Source files
------------

// File: rtl/store_unit.sv
// Store unit: accepts one SB/SH/SW at a time, checks alignment, issues a
// lane-aligned write to the data cache controller and hands the instruction
// packet back to commit with a valid/accept handshake.
//
// Handshakes:
//  - Request side: a store is taken on a rising clk_i edge when idle_o,
//    valid_operation_i and cache_ctrl_idle_i are all high. The requester holds
//    its inputs stable until then.
//  - Cache side: cache_ctrl_write_o stays high with stable address/data/byte
//    enable/cachable until cache_ctrl_done_i is seen high on an edge.
//  - Result side: done_o (with misaligned_o and instr_packet_o) holds until
//    data_accepted_i is seen high on an edge. New requests are ignored until
//    the unit is back in IDLE.
module store_unit #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     PACKET_W       = 64,
  parameter logic [XLEN-1:0] CACHABLE_START = 32'h0000_0000,
  parameter logic [XLEN-1:0] CACHABLE_END   = 32'h3FFF_FFFF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                valid_operation_i,
  input  logic [XLEN-1:0]     store_address_i,
  input  logic [XLEN-1:0]     store_data_i,
  input  logic [1:0]          operation_i,
  input  logic [PACKET_W-1:0] instr_packet_i,
  input  logic                data_accepted_i,
  output logic [PACKET_W-1:0] instr_packet_o,
  output logic                done_o,
  output logic                misaligned_o,
  output logic                idle_o,
  input  logic                cache_ctrl_idle_i,
  input  logic                cache_ctrl_done_i,
  output logic                cache_ctrl_write_o,
  output logic [XLEN-1:0]     cache_ctrl_address_o,
  output logic [XLEN-1:0]     cache_ctrl_data_o,
  output logic [3:0]          cache_ctrl_byte_enable_o,
  output logic                cache_ctrl_cachable_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_CACHE = 2'b01,
    DONE       = 2'b10
  } state_t;

  state_t          state_q;
  logic            misaligned_q;

  logic [XLEN-1:0] fmt_data;
  logic [3:0]      fmt_be;
  logic            fmt_misaligned;
  logic [XLEN-1:0] range_off;
  logic            in_range;

  // Lane formatting and alignment check of the incoming request.
  always_comb begin
    fmt_data       = store_data_i;
    fmt_be         = 4'b1111;
    fmt_misaligned = 1'b0;
    case (operation_i)
      2'b00: begin
        fmt_data = {4{store_data_i[7:0]}};
        fmt_be   = 4'b0001 << store_address_i[1:0];
      end
      2'b01: begin
        fmt_data       = {2{store_data_i[15:0]}};
        fmt_be         = store_address_i[1] ? 4'b1100 : 4'b0011;
        fmt_misaligned = store_address_i[0];
      end
      default: begin
        // 10 is SW; 11 is treated as SW as well.
        fmt_data       = store_data_i;
        fmt_be         = 4'b1111;
        fmt_misaligned = (store_address_i[1:0] != 2'b00);
      end
    endcase
  end

  // Unsigned inclusive range test written as an offset compare so that a
  // region starting at zero does not degenerate into a constant comparison.
  always_comb begin
    range_off = store_address_i - CACHABLE_START;
    in_range  = (range_off <= (CACHABLE_END - CACHABLE_START));
  end

  // Control FSM plus the request latches it owns.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q                  <= IDLE;
      misaligned_q             <= 1'b0;
      instr_packet_o           <= '0;
      cache_ctrl_address_o     <= '0;
      cache_ctrl_data_o        <= '0;
      cache_ctrl_byte_enable_o <= 4'b0000;
      cache_ctrl_cachable_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_operation_i && cache_ctrl_idle_i) begin
            instr_packet_o        <= instr_packet_i;
            cache_ctrl_address_o  <= {store_address_i[XLEN-1:2], 2'b00};
            cache_ctrl_data_o     <= fmt_data;
            cache_ctrl_cachable_o <= in_range;
            misaligned_q          <= fmt_misaligned;
            if (fmt_misaligned) begin
              cache_ctrl_byte_enable_o <= 4'b0000;
              state_q                  <= DONE;
            end else begin
              cache_ctrl_byte_enable_o <= fmt_be;
              state_q                  <= WAIT_CACHE;
            end
          end
        end
        WAIT_CACHE: begin
          if (cache_ctrl_done_i) state_q <= DONE;
        end
        DONE: begin
          if (data_accepted_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status outputs decode the state register alone, so they follow an
  // asynchronous reset in the same cycle.
  assign idle_o             = (state_q == IDLE);
  assign cache_ctrl_write_o = (state_q == WAIT_CACHE);
  assign done_o             = (state_q == DONE);
  assign misaligned_o       = (state_q == DONE) && misaligned_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed scenarios followed by randomized stores,
// with a behavioural model feeding expected-result queues that an
// independent monitor drains.
module tb_store_unit;

  localparam int XLEN = 32;
  localparam int PW   = 64;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst_n;
  logic          valid_operation;
  logic [31:0]   store_address;
  logic [31:0]   store_data;
  logic [1:0]    operation;
  logic [PW-1:0] instr_packet_in;
  logic          data_accepted;
  logic [PW-1:0] instr_packet_out;
  logic          done;
  logic          misaligned;
  logic          idle;
  logic          cache_idle;
  logic          cache_done;
  logic          cache_write;
  logic [31:0]   cache_address;
  logic [31:0]   cache_data;
  logic [3:0]    cache_be;
  logic          cache_cachable;

  store_unit #(.XLEN(XLEN), .PACKET_W(PW)) dut (
    .clk_i                    (clk),
    .rst_n_i                  (rst_n),
    .valid_operation_i        (valid_operation),
    .store_address_i          (store_address),
    .store_data_i             (store_data),
    .operation_i              (operation),
    .instr_packet_i           (instr_packet_in),
    .data_accepted_i          (data_accepted),
    .instr_packet_o           (instr_packet_out),
    .done_o                   (done),
    .misaligned_o             (misaligned),
    .idle_o                   (idle),
    .cache_ctrl_idle_i        (cache_idle),
    .cache_ctrl_done_i        (cache_done),
    .cache_ctrl_write_o       (cache_write),
    .cache_ctrl_address_o     (cache_address),
    .cache_ctrl_data_o        (cache_data),
    .cache_ctrl_byte_enable_o (cache_be),
    .cache_ctrl_cachable_o    (cache_cachable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [3:0]    be;
    logic          cach;
    logic          mis;
    logic [PW-1:0] pkt;
  } exp_t;

  exp_t wr_q[$];
  exp_t res_q[$];
  int   vectors;
  int   miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sizes, modulo arithmetic and multiplicative replication.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] op, input logic [PW-1:0] pkt);
    exp_t        e;
    int unsigned size;
    size   = (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
    e.pkt  = pkt;
    e.mis  = ((a % size) != 0);
    e.addr = a - (a % 4);
    e.cach = (a <= 32'h3FFF_FFFF);
    if (size == 1) begin
      e.data = 32'(d[7:0]) * 32'h0101_0101;
      e.be   = 4'(1 << (a % 4));
    end else if (size == 2) begin
      e.data = 32'(d[15:0]) * 32'h0001_0001;
      e.be   = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    end else begin
      e.data = d;
      e.be   = 4'b1111;
    end
    if (e.mis) e.be = 4'b0000;
    return e;
  endfunction

  // Monitor: compares every presented write and result against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cache_write) begin
          if (wr_q.size() == 0) begin
            check("unexpected_write", 64'(cache_write), 64'd0);
          end else begin
            check("write_addr", 64'(cache_address), 64'(wr_q[0].addr));
            check("write_data", 64'(cache_data), 64'(wr_q[0].data));
            check("write_be", 64'(cache_be), 64'(wr_q[0].be));
            check("write_cachable", 64'(cache_cachable), 64'(wr_q[0].cach));
            if (cache_done) void'(wr_q.pop_front());
          end
        end
        if (done) begin
          if (res_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
          end else begin
            check("done_misaligned", 64'(misaligned), 64'(res_q[0].mis));
            check("done_packet", instr_packet_out, res_q[0].pkt);
            if (res_q[0].mis) check("mis_be_zero", 64'(cache_be), 64'd0);
            if (data_accepted) void'(res_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op,
                          input logic [PW-1:0] pkt, input int stall, input int dly,
                          input int hold, input bit poke);
    exp_t e;
    e = model(a, d, op, pkt);
    @(posedge clk); #1;
    valid_operation = 1'b1;
    store_address   = a;
    store_data      = d;
    operation       = op;
    instr_packet_in = pkt;
    cache_idle      = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_idle", 64'(idle), 64'd1);
      check("stall_no_write", 64'(cache_write), 64'd0);
      check("stall_no_done", 64'(done), 64'd0);
      @(posedge clk); #1;
    end
    cache_idle = 1'b1;
    @(negedge clk);
    check("accept_idle", 64'(idle), 64'd1);
    res_q.push_back(e);
    if (!e.mis) wr_q.push_back(e);
    @(posedge clk); #1;
    // Junk request held during WAIT_CACHE/DONE must be ignored.
    valid_operation = poke;
    store_address   = $urandom;
    store_data      = $urandom;
    operation       = 2'($urandom_range(0, 3));
    instr_packet_in = {$urandom, $urandom};
    @(negedge clk);
    if (e.mis) begin
      check("mis_done_latency", 64'(done), 64'd1);
      check("mis_no_write", 64'(cache_write), 64'd0);
    end else begin
      check("write_latency", 64'(cache_write), 64'd1);
      check("write_not_done", 64'(done), 64'd0);
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("write_held", 64'(cache_write), 64'd1);
      end
      @(posedge clk); #1;
      cache_done = 1'b1;
      @(posedge clk); #1;
      cache_done = 1'b0;
      @(negedge clk);
      check("done_latency", 64'(done), 64'd1);
      check("done_write_low", 64'(cache_write), 64'd0);
    end
    check("done_not_idle", 64'(idle), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("done_hold", 64'(done), 64'd1);
      check("hold_no_write", 64'(cache_write), 64'd0);
    end
    @(posedge clk); #1;
    data_accepted = 1'b1;
    @(posedge clk); #1;
    data_accepted   = 1'b0;
    valid_operation = 1'b0;
    @(negedge clk);
    check("back_idle", 64'(idle), 64'd1);
    check("back_not_done", 64'(done), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    valid_operation = 1'b0;
    store_address   = '0;
    store_data      = '0;
    operation       = 2'd0;
    instr_packet_in = '0;
    data_accepted   = 1'b0;
    cache_idle      = 1'b1;
    cache_done      = 1'b0;
    #1;
    check("rst_done", 64'(done), 64'd0);
    check("rst_misaligned", 64'(misaligned), 64'd0);
    check("rst_write", 64'(cache_write), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_addr", 64'(cache_address), 64'd0);
    check("rst_data", 64'(cache_data), 64'd0);
    check("rst_be", 64'(cache_be), 64'd0);
    check("rst_packet", instr_packet_out, 64'd0);
    check("rst_cachable", 64'(cache_cachable), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed scenarios.
    do_store(32'h0000_1003, 32'hAABB_CCDD, 2'b00, 64'h1111, 0, 0, 0, 0);
    do_store(32'h0000_2002, 32'h1234_5678, 2'b01, 64'h2222, 0, 1, 1, 0);
    do_store(32'h0000_2000, 32'hCAFE_BABE, 2'b10, 64'h3333, 0, 4, 2, 1);
    do_store(32'h0000_2001, 32'h0BAD_F00D, 2'b10, 64'h4444, 0, 0, 1, 0);
    do_store(32'h0000_2001, 32'h0BAD_F00D, 2'b01, 64'h5555, 0, 0, 0, 1);
    do_store(32'h0000_3000, 32'h5A5A_A5A5, 2'b11, 64'h6666, 3, 1, 2, 1);
    do_store(32'h4000_0000, 32'h0102_0304, 2'b10, 64'h7777, 0, 0, 0, 0);
    do_store(32'h3FFF_FFFC, 32'h0506_0708, 2'b10, 64'h8888, 0, 0, 0, 0);

    // Reset while a write is outstanding.
    @(posedge clk); #1;
    valid_operation = 1'b1;
    store_address   = 32'h0000_5000;
    store_data      = 32'hDEAD_BEEF;
    operation       = 2'b10;
    instr_packet_in = 64'h9999;
    @(negedge clk);
    wr_q.push_back(model(32'h0000_5000, 32'hDEAD_BEEF, 2'b10, 64'h9999));
    res_q.push_back(model(32'h0000_5000, 32'hDEAD_BEEF, 2'b10, 64'h9999));
    @(posedge clk); #1;
    valid_operation = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_write", 64'(cache_write), 64'd0);
    check("midrst_idle", 64'(idle), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_addr", 64'(cache_address), 64'd0);
    check("midrst_packet", instr_packet_out, 64'd0);
    wr_q.delete();
    res_q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    do_store(32'h0000_6002, 32'h0000_00EE, 2'b00, 64'hAAAA, 0, 0, 0, 0);

    // Randomized stores.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'h3FFF_FFF0 + 32'($urandom_range(0, 31));
        2:       a = 32'($urandom_range(0, 16'hFFFF));
        default: a = $urandom;
      endcase
      do_store(a, $urandom, 2'($urandom_range(0, 3)), {$urandom, $urandom},
               $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    check("res_queue_drained", 64'(res_q.size()), 64'd0);
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
